// File: rtl/spi_xfer_sequencer.sv
// Byte-stream sequencer between a TX/RX FIFO pair and a single-byte SPI master driver.
// At most one transfer is in flight; a watchdog aborts transfers the driver never completes.
module spi_xfer_sequencer #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              tx_data,
  input  logic                    tx_valid,
  output logic                    tx_ready,
  output logic [7:0]              rx_data,
  output logic                    rx_valid,
  input  logic                    rx_ready,
  output logic [7:0]              drv_data_in,
  output logic                    drv_start,
  input  logic                    drv_en,
  input  logic [7:0]              drv_data_out,
  output logic                    busy,
  output logic                    err,
  input  logic                    err_clr,
  output logic [$clog2(DEPTH):0]  tx_level,
  output logic [$clog2(DEPTH):0]  rx_level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [LW-1:0] FULL    = LW'(DEPTH);
  localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_EN   = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t          state_r, state_s;
  logic [7:0]      tx_mem [DEPTH];
  logic [7:0]      rx_mem [DEPTH];
  logic [AW-1:0]   tx_wptr_r, tx_rptr_r, rx_wptr_r, rx_rptr_r;
  logic [LW-1:0]   tx_level_r, rx_level_r;
  logic [CW-1:0]   wdog_r;
  logic [7:0]      drv_data_r;
  logic            drv_start_r, err_r;
  logic            launch_s, rx_push_s, timeout_s, tx_wr_s, rx_pop_s, wd_last_s;

  assign tx_wr_s   = tx_valid && (tx_level_r != FULL);
  assign rx_pop_s  = rx_ready && (rx_level_r != LW'(0));
  assign wd_last_s = (wdog_r == WD_LAST);

  // FIFO storage arrays; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (tx_wr_s)   tx_mem[tx_wptr_r] <= tx_data;
    if (rx_push_s) rx_mem[rx_wptr_r] <= drv_data_out;
  end

  // FIFO pointers and occupancy; the launch edge is the only TX pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_wptr_r  <= AW'(0);
      tx_rptr_r  <= AW'(0);
      tx_level_r <= LW'(0);
      rx_wptr_r  <= AW'(0);
      rx_rptr_r  <= AW'(0);
      rx_level_r <= LW'(0);
    end else begin
      if (tx_wr_s)   tx_wptr_r <= tx_wptr_r + AW'(1);
      if (launch_s)  tx_rptr_r <= tx_rptr_r + AW'(1);
      if (tx_wr_s && !launch_s)      tx_level_r <= tx_level_r + LW'(1);
      else if (!tx_wr_s && launch_s) tx_level_r <= tx_level_r - LW'(1);
      if (rx_push_s) rx_wptr_r <= rx_wptr_r + AW'(1);
      if (rx_pop_s)  rx_rptr_r <= rx_rptr_r + AW'(1);
      if (rx_push_s && !rx_pop_s)      rx_level_r <= rx_level_r + LW'(1);
      else if (!rx_push_s && rx_pop_s) rx_level_r <= rx_level_r - LW'(1);
    end
  end

  // Next-state logic; launching only with RX space free reserves the slot for the reply
  always_comb begin
    state_s   = state_r;
    launch_s  = 1'b0;
    rx_push_s = 1'b0;
    timeout_s = 1'b0;
    case (state_r)
      IDLE: begin
        if ((tx_level_r != LW'(0)) && (rx_level_r != FULL) && !err_r) begin
          state_s  = WAIT_EN;
          launch_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      WAIT_EN: begin
        if (drv_en) begin
          state_s = WAIT_DONE;
        end else if (wd_last_s) begin
          state_s   = IDLE;
          timeout_s = 1'b1;
        end else begin
          state_s = WAIT_EN;
        end
      end
      WAIT_DONE: begin
        if (!drv_en) begin
          state_s   = IDLE;
          rx_push_s = 1'b1;
        end else if (wd_last_s) begin
          state_s   = IDLE;
          timeout_s = 1'b1;
        end else begin
          state_s = WAIT_DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, driver handshake, watchdog and sticky error registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      drv_start_r <= 1'b0;
      drv_data_r  <= 8'h00;
      wdog_r      <= CW'(0);
      err_r       <= 1'b0;
    end else begin
      state_r     <= state_s;
      drv_start_r <= launch_s;
      if (launch_s) drv_data_r <= tx_mem[tx_rptr_r];
      // Saturates so a late WAIT_EN exit still times out in WAIT_DONE
      if (launch_s)                              wdog_r <= CW'(0);
      else if ((state_r != IDLE) && !wd_last_s)  wdog_r <= wdog_r + CW'(1);
      if (timeout_s)    err_r <= 1'b1;
      else if (err_clr) err_r <= 1'b0;
    end
  end

  assign tx_ready    = (tx_level_r != FULL);
  assign rx_valid    = (rx_level_r != LW'(0));
  assign rx_data     = rx_valid ? rx_mem[rx_rptr_r] : 8'h00;
  assign drv_data_in = drv_data_r;
  assign drv_start   = drv_start_r;
  assign busy        = (state_r != IDLE);
  assign err         = err_r;
  assign tx_level    = tx_level_r;
  assign rx_level    = rx_level_r;

endmodule
